// File: rtl/proj_sig_stream.sv
// Frame sequencer and 2-stage multiplicative hash feeding the MinHash smallest-K sorter.
// Emits one (signature, index) pair per accepted word, with clear/done pulses around each frame.
module proj_sig_stream #(
  parameter int          DATA_LEN      = 32,
  parameter int          SIGNATURE_LEN = 32,
  parameter int          INDICE_LEN    = 8,
  parameter logic [31:0] HASH_A        = 32'h9E3779B1,
  parameter logic [31:0] HASH_B        = 32'h7F4A7C15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_LEN-1:0]      in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  output logic [SIGNATURE_LEN-1:0] out_signature,
  output logic [INDICE_LEN-1:0]    out_index,
  output logic                     out_sorter_clr,
  output logic                     frame_done,
  output logic                     idx_overflow
);

  localparam int PROD_LEN = DATA_LEN + SIGNATURE_LEN;
  localparam logic [SIGNATURE_LEN-1:0] SIG_ONES = {SIGNATURE_LEN{1'b1}};
  localparam logic [SIGNATURE_LEN-1:0] SIG_CAP  = {{(SIGNATURE_LEN-1){1'b1}}, 1'b0};
  localparam logic [INDICE_LEN-1:0]    IDX_MAX  = {INDICE_LEN{1'b1}};

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t                   state;
  logic                     accept;
  logic [INDICE_LEN-1:0]    idx_cnt;
  logic                     v1;
  logic [PROD_LEN-1:0]      p1;
  logic [INDICE_LEN-1:0]    idx1;
  logic                     v2;
  logic [SIGNATURE_LEN-1:0] s2;
  logic [INDICE_LEN-1:0]    idx2;

  // Fold the high product half onto the low half, then offset.
  function automatic logic [SIGNATURE_LEN-1:0] mix(input logic [PROD_LEN-1:0] p);
    logic [SIGNATURE_LEN-1:0] hi;
    hi = SIGNATURE_LEN'(p[PROD_LEN-1 -: DATA_LEN]);
    return (p[SIGNATURE_LEN-1:0] ^ hi) + SIGNATURE_LEN'(HASH_B);
  endfunction

  assign accept = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      out_sorter_clr <= 1'b0;
      frame_done     <= 1'b0;
      idx_cnt        <= '0;
      idx_overflow   <= 1'b0;
    end else begin
      out_sorter_clr <= 1'b0;
      frame_done     <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state          <= CLEAR;
          out_sorter_clr <= 1'b1;
          idx_cnt        <= '0;
          idx_overflow   <= 1'b0;
        end
        CLEAR: begin
          state    <= RUN;
          in_ready <= 1'b1;
        end
        RUN: begin
          if (accept) begin
            idx_cnt <= idx_cnt + 1'b1;
            if (idx_cnt == IDX_MAX && !in_last) idx_overflow <= 1'b1;
            if (in_last) begin
              state    <= DRAIN;
              in_ready <= 1'b0;
            end
          end
        end
        // Hold off the done pulse until the last word has cleared both hash stages.
        DRAIN: begin
          if (!v1 && !v2) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1            <= 1'b0;
      p1            <= '0;
      idx1          <= '0;
      v2            <= 1'b0;
      s2            <= '0;
      idx2          <= '0;
      out_valid     <= 1'b0;
      out_signature <= '0;
      out_index     <= '0;
    end else begin
      v1 <= accept;
      if (accept) begin
        p1   <= PROD_LEN'(HASH_A) * PROD_LEN'(in_data);
        idx1 <= idx_cnt;
      end
      v2 <= v1;
      if (v1) begin
        s2   <= mix(p1);
        idx2 <= idx1;
      end
      // All-ones is the sorter's empty marker, so it is never emitted as a signature.
      out_valid <= v2;
      if (v2) begin
        out_signature <= (s2 == SIG_ONES) ? SIG_CAP : s2;
        out_index     <= idx2;
      end
    end
  end

endmodule

// File: tb/tb_proj_sig_stream.sv
// Bench for proj_sig_stream: a default instance and a narrow-index instance whose offset makes
// word 0 hash to all-ones, both compared every cycle against a schedule-based model.
module tb_proj_sig_stream;

  localparam logic [31:0] HA   = 32'h9E3779B1;
  localparam logic [31:0] HB_A = 32'h7F4A7C15;
  localparam logic [31:0] HB_B = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_last = 1'b0;

  logic        in_ready_a, out_valid_a, clr_a, done_a, ovf_a;
  logic [31:0] sig_a;
  logic [7:0]  idx_a;
  logic        in_ready_b, out_valid_b, clr_b, done_b, ovf_b;
  logic [31:0] sig_b;
  logic [1:0]  idx_b;

  proj_sig_stream dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_a), .out_signature(sig_a), .out_index(idx_a),
    .out_sorter_clr(clr_a), .frame_done(done_a), .idx_overflow(ovf_a)
  );

  proj_sig_stream #(.INDICE_LEN(2), .HASH_B(HB_B)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_signature(sig_b), .out_index(idx_b),
    .out_sorter_clr(clr_b), .frame_done(done_b), .idx_overflow(ovf_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] hash_m(input logic [31:0] d, input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] s;
    p = {32'h0, HA} * {32'h0, d};
    s = (p[31:0] ^ p[63:32]) + b;
    if (s == 32'hFFFFFFFF) s = 32'hFFFFFFFE;
    return s;
  endfunction

  // Model: pending outputs with their due edge, plus edge numbers for clear/done/ready events.
  typedef struct {
    logic [31:0] sa;
    logic [31:0] sb;
    logic [7:0]  ia;
    logic [1:0]  ib;
    int          due;
  } pend_t;

  pend_t       q[$];
  bit          started = 1'b0;
  int          k = 0;
  int          clr_at = 1;
  int          done_at = -1;
  int          cnt_a = 0;
  int          cnt_b = 0;
  logic        e_ready = 1'b0, e_clr = 1'b0, e_done = 1'b0, e_valid = 1'b0;
  logic        e_ovf_a = 1'b0, e_ovf_b = 1'b0;
  logic [31:0] e_sig_a = 32'h0, e_sig_b = 32'h0;
  logic [7:0]  e_idx_a = 8'h0;
  logic [1:0]  e_idx_b = 2'h0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      started = 1'b1; k = 0; q.delete(); clr_at = 1; done_at = -1;
      cnt_a = 0; cnt_b = 0; e_ready = 1'b0; e_clr = 1'b0; e_done = 1'b0; e_valid = 1'b0;
      e_ovf_a = 1'b0; e_ovf_b = 1'b0; e_sig_a = 32'h0; e_sig_b = 32'h0;
      e_idx_a = 8'h0; e_idx_b = 2'h0;
    end else if (started) begin
      pend_t pe;
      k++;
      if (in_valid && e_ready) begin
        pe.sa = hash_m(in_data, HB_A); pe.sb = hash_m(in_data, HB_B);
        pe.ia = 8'(cnt_a); pe.ib = 2'(cnt_b); pe.due = k + 2;
        q.push_back(pe);
        if (cnt_a == 255 && !in_last) e_ovf_a = 1'b1;
        if (cnt_b == 3 && !in_last) e_ovf_b = 1'b1;
        cnt_a = (cnt_a + 1) % 256;
        cnt_b = (cnt_b + 1) % 4;
        if (in_last) begin
          e_ready = 1'b0; done_at = k + 3; clr_at = k + 4;
        end
      end
      e_clr = (k == clr_at);
      if (e_clr) begin
        cnt_a = 0; cnt_b = 0; e_ovf_a = 1'b0; e_ovf_b = 1'b0;
      end
      if (k == clr_at + 1) e_ready = 1'b1;
      e_done  = (k == done_at);
      e_valid = 1'b0;
      if (q.size() > 0 && q[0].due == k) begin
        pe = q.pop_front();
        e_valid = 1'b1;
        e_sig_a = pe.sa; e_sig_b = pe.sb; e_idx_a = pe.ia; e_idx_b = pe.ib;
      end
    end
  end

  // Log of actual outputs of the default instance, used by the directed checks.
  int          log_k[$];
  logic [31:0] log_sig_a[$];
  logic [31:0] log_sig_b[$];
  logic [7:0]  log_idx_a[$];
  logic [1:0]  log_idx_b[$];
  int          done_k = -1;

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("in_ready_a", in_ready_a, e_ready);
      check("in_ready_b", in_ready_b, e_ready);
      check("clr_a", clr_a, e_clr);
      check("clr_b", clr_b, e_clr);
      check("done_a", done_a, e_done);
      check("done_b", done_b, e_done);
      check("valid_a", out_valid_a, e_valid);
      check("valid_b", out_valid_b, e_valid);
      check("sig_a", sig_a, e_sig_a);
      check("sig_b", sig_b, e_sig_b);
      check("idx_a", idx_a, e_idx_a);
      check("idx_b", idx_b, e_idx_b);
      check("ovf_a", ovf_a, e_ovf_a);
      check("ovf_b", ovf_b, e_ovf_b);
      if (out_valid_a === 1'b1) begin
        log_k.push_back(k); log_sig_a.push_back(sig_a); log_sig_b.push_back(sig_b);
        log_idx_a.push_back(idx_a); log_idx_b.push_back(idx_b);
      end
      if (done_a === 1'b1) done_k = k;
    end
  end

  task automatic clear_log();
    log_k.delete(); log_sig_a.delete(); log_sig_b.delete();
    log_idx_a.delete(); log_idx_b.delete(); done_k = -1;
  endtask

  task automatic send(input logic [31:0] d, input logic last);
    int   n;
    logic was;
    n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    do begin
      was = in_ready_a;
      @(negedge clk);
      n++;
    end while (!was && n < 100);
    check("send_accepted", was, 1'b1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("frame_done_seen", done_a, 1'b1);
  endtask

  task automatic wait_clr();
    int n;
    n = 0;
    while (clr_a !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("sorter_clr_seen", clr_a, 1'b1);
  endtask

  initial begin
    logic [1:0] ovf_idx[6];
    ovf_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset then idle
    @(negedge clk);
    check("t1_clr_edge2", clr_a, 1'b1);
    check("t1_ready_low", in_ready_a, 1'b0);
    @(negedge clk);
    check("t1_ready_edge3", in_ready_a, 1'b1);
    check("t1_clr_low", clr_a, 1'b0);

    // Four back-to-back words
    clear_log();
    send(32'd0, 1'b0); send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd3, 1'b1);
    wait_done();
    check("t2_count", log_k.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_index", log_idx_a[i], 8'(i));
    check("t2_sig_data0", log_sig_a[0], 32'h7F4A7C15);
    check("t2_sig_data1", log_sig_a[1], 32'h1D81F5C6);
    check("t2_consecutive", log_k[3] - log_k[0], 3);
    check("t2_done_gap", done_k - log_k[3], 1);
    check("t5_allones_capped", log_sig_b[0], 32'hFFFFFFFE);

    // Gapped valid 1-0-1-1
    clear_log();
    send(32'd10, 1'b0); idle(1); send(32'd11, 1'b0); send(32'd12, 1'b1);
    wait_done();
    check("t3_count", log_k.size(), 3);
    for (int i = 0; i < 3; i++) check("t3_index", log_idx_a[i], 8'(i));
    check("t3_gap", log_k[1] - log_k[0], 2);
    check("t3_nogap", log_k[2] - log_k[1], 1);

    // Six words into a 2-bit index
    clear_log();
    for (int i = 0; i < 6; i++) send(32'(20 + i), (i == 5) ? 1'b1 : 1'b0);
    wait_done();
    check("t4_count", log_idx_b.size(), 6);
    for (int i = 0; i < 6; i++) check("t4_index_wrap", log_idx_b[i], ovf_idx[i]);
    check("t4_ovf_b_set", ovf_b, 1'b1);
    check("t4_ovf_a_clear", ovf_a, 1'b0);
    wait_clr();
    check("t4_ovf_b_cleared", ovf_b, 1'b0);

    // Reset with two words in flight
    clear_log();
    send(32'd30, 1'b0); send(32'd31, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_ready_after_rst", in_ready_a, 1'b0);
    repeat (4) @(negedge clk);
    check("t6_no_output", log_k.size(), 0);
    send(32'd40, 1'b0); send(32'd41, 1'b1);
    wait_done();
    check("t6_count", log_k.size(), 2);
    check("t6_index0", log_idx_a[0], 8'd0);
    check("t6_index1", log_idx_a[1], 8'd1);

    idle(3);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
